mpu_scalar_mul_seq: RTL and testbench
=====================================

// Module: mpu_scalar_mul_seq
// PURPOSE
//  Sequencer for the MPU integer scalar-multiply operation (matrix * factor).
//  - Walks a DIMxDIM matrix in row-major order: reads each element from the matrix buffer,
//    multiplies it by a factor latched at start, and writes the product to the result buffer.
//  - A single shared multiplier replaces the DIM*DIM parallel multipliers.
//  - Sits between the MPU instruction decoder (start/done) and the matrix/result buffers.
// PARAMETERS
//  DIM     5  matrix rows = cols
//  WIDTH   8  element and factor width, bits
//  ADDR_W  5  buffer address width; must satisfy 2**ADDR_W >= DIM*DIM
// PORTS
//  clk      in   1       clock; all logic on rising edge
//  rst_n    in   1       synchronous reset, active-low
//  start    in   1       one-cycle op request; honoured only in IDLE
//  abort    in   1       cancel the running op
//  factor   in   WIDTH   scalar operand, sampled on accepted start
//  rd_en    out  1       matrix-buffer read strobe
//  rd_addr  out  ADDR_W  matrix-buffer address = row*DIM+col
//  rd_data  in   WIDTH   read data, valid exactly 1 cycle after rd_en
//  wr_en    out  1       result-buffer write strobe
//  wr_addr  out  ADDR_W  result-buffer address, same mapping as rd_addr
//  wr_data  out  WIDTH   product written
//  busy     out  1       op in progress
//  done     out  1       one-cycle completion pulse
//  ovf      out  1       sticky: an element saturated (MPU_SATURATE_EN only, else 0)
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//  - All outputs go to 0; FSM goes to IDLE; factor register, counters and ovf clear.
//  - Reset mid-op discards the op silently: no done, no further writes.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE: start=1 latches factor, clears ovf, enters RUN; busy rises next cycle (call it cycle 1).
//  - RUN: one read per cycle.
//    - rd_en=1, rd_addr = 0,1,...,DIM*DIM-1 on cycles 1..DIM*DIM.
//    - After the read of the last address, enter DRAIN.
//  - Pipeline:
//    - Read issued in cycle t; rd_data sampled in t+1.
//    - Product registered; wr_en/wr_addr/wr_data valid in t+2.
//    - Writes occur on cycles 3..DIM*DIM+2 (3..27 at defaults).
//  - DRAIN: rd_en=0; stay until the final write is issued, then enter DONE.
//  - DONE: done=1 and busy=0 for exactly one cycle (cycle 28 at defaults), then IDLE.
//  - busy=1 in RUN and DRAIN only.
//  - wr_en is high only for valid pipeline slots; exactly DIM*DIM writes per completed op.
//  Arithmetic:
//  - Unsigned WIDTH x WIDTH -> 2*WIDTH full product.
//  - wr_data = product[WIDTH-1:0] (wrap-around) unless saturation is enabled.
//  Boundary conditions:
//  - start while busy or in DONE: ignored.
//  - start in the same cycle done is high: ignored.
//  - abort in RUN/DRAIN:
//    - Next cycle is IDLE; rd_en/wr_en/busy=0 from that cycle.
//    - In-flight reads are dropped and never written; no done pulse.
//  - abort in IDLE or DONE: no effect; DONE still pulses.
//  - start and abort together in IDLE: start accepted, abort ignored.
//  - factor=0: full op still runs; all 25 writes are 0.
//  - factor changes during an op: no effect (latched value used).
// CONFIGURATION
//  MPU_SATURATE_EN defined:
//  - wr_data = (product > 2**WIDTH-1) ? {WIDTH{1'b1}} : product[WIDTH-1:0].
//  - ovf sets on any saturated write and stays set until the next accepted start or reset.
//  MPU_SATURATE_EN undefined:
//  - Truncation only; ovf tied to 0.
// TESTING
//  1. factor=3, matrix[k]=k (k=0..24), start -> 25 writes addr k data 3k on cycles 3..27; done pulses on cycle 28 only.
//  2. factor=16, element 0x20 -> no macro: wr_data=0x00, ovf=0.
//     With MPU_SATURATE_EN: wr_data=0xFF, ovf=1 until next start.
//  3. abort on cycle 10 -> last write at most addr 7; busy/rd_en/wr_en=0 from cycle 11; no done.
//     A new start afterwards runs a full 25-write op.
//  4. start pulsed on cycles 5 and 28 of a running op -> both ignored; exactly 25 writes; one done.
//  5. rst_n=0 on cycle 12 -> next cycle all outputs 0, IDLE; no done; ovf cleared.
//  6. factor=0xFF, all elements 0x01 -> 25 writes of 0xFF, ovf=0 in both builds.
//     Then factor=0 -> 25 writes of 0x00.

Source files
------------

// File: rtl/mpu_scalar_mul_seq.sv
// mpu_scalar_mul_seq
// Sequencer for the MPU integer scalar-multiply (matrix * factor).
// Walks a DIM x DIM matrix in row-major order through one shared multiplier:
// read address k in cycle t, sample rd_data in t+1, write the registered
// product to the result buffer in t+2.
//
// Optional feature macro: MPU_SATURATE_EN
//   defined   : products above 2**WIDTH-1 clamp to all-ones and set sticky ovf
//   undefined : products wrap (low WIDTH bits kept), ovf tied to 0
//
// Handshake notes: start is a one-cycle request honoured only in IDLE (no
// ready back-pressure; the caller watches busy/done). rd_en is a strobe whose
// data returns exactly one cycle later with no stall. wr_en marks one valid
// result-buffer write per cycle; the buffer always accepts it.
module mpu_scalar_mul_seq #(
  parameter int DIM    = 5,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  factor,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DIM * DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // state is the debug-visible FSM state; checkers bind to it directly.
  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]  factor_q;
  logic [ADDR_W-1:0] rd_cnt;
  logic              s1_vld;
  logic [ADDR_W-1:0] s1_addr;
  logic              start_acc;
  logic              kill;
  logic [WIDTH-1:0]  prod_val;

  // An accepted start only exists in IDLE; abort only matters while busy.
  assign start_acc = (state == IDLE) && start;
  assign kill      = abort && ((state == RUN) || (state == DRAIN));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (rd_cnt == LAST_ADDR) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (wr_en && (wr_addr == LAST_ADDR)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read address counter is only non-zero while reads are being issued.
  assign rd_addr = rd_cnt;

  // Read address counter: steps once per RUN cycle, cleared otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if ((state == RUN) && !abort && (rd_cnt != LAST_ADDR)) begin
      rd_cnt <= rd_cnt + 1'b1;
    end else begin
      rd_cnt <= '0;
    end
  end

  // Factor is captured once per op so later changes on the port are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      factor_q <= '0;
    end else if (start_acc) begin
      factor_q <= factor;
    end
  end

  // Stage 1 remembers which address the returning rd_data belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_vld  <= rd_en && !kill;
      s1_addr <= rd_addr;
    end
  end

`ifdef MPU_SATURATE_EN
  logic [2*WIDTH-1:0] prod_full;
  logic               prod_sat;

  assign prod_full = rd_data * factor_q;
  assign prod_sat  = (prod_full[2*WIDTH-1:WIDTH] != '0);
  assign prod_val  = prod_sat ? {WIDTH{1'b1}} : prod_full[WIDTH-1:0];

  // Sticky overflow: set by any clamped write, cleared by the next op start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (start_acc) begin
      ovf <= 1'b0;
    end else if (s1_vld && !kill && prod_sat) begin
      ovf <= 1'b1;
    end
  end
`else
  // Wrap-around: only the low WIDTH bits of the product are kept.
  assign prod_val = WIDTH'(rd_data * factor_q);
  assign ovf      = 1'b0;
`endif

  // Write stage: registered product, address and strobe; abort drops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= s1_vld && !kill;
      if (s1_vld && !kill) begin
        wr_addr <= s1_addr;
        wr_data <= prod_val;
      end
    end
  end

endmodule

// File: tb/tb_mpu_scalar_mul_seq.sv
// Bench for mpu_scalar_mul_seq: directed timing/boundary checks plus random
// ops, with a write scoreboard fed by a reference model of the matrix op.
module tb_mpu_scalar_mul_seq;

  localparam int DIM    = 5;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 5;
  localparam int N      = DIM * DIM;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  factor;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic              ovf;

  mpu_scalar_mul_seq #(.DIM(DIM), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .factor(factor),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- matrix buffer model ----------------
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // Read data returns one cycle after the strobe.
  always @(posedge clk) rd_data <= mem[rd_addr];

  // ---------------- scoreboard ----------------
  logic [ADDR_W+WIDTH-1:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int done_cnt;
  int exp_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one element of matrix * factor under the build's arithmetic rule.
  function automatic logic [WIDTH-1:0] ref_elem(input int f, input int e);
    int p;
    p = f * e;
`ifdef MPU_SATURATE_EN
    if (p > 255) p = 255;
`else
    p = p % 256;
`endif
    return WIDTH'(p);
  endfunction

  // Reference overflow flag after a completed op.
  function automatic logic ref_ovf(input int f);
    logic o;
    o = 1'b0;
`ifdef MPU_SATURATE_EN
    for (int k = 0; k < N; k++) if (f * int'(mem[k]) > 255) o = 1'b1;
`endif
    return o;
  endfunction

  // Expect the first n writes of an op in row-major order.
  task automatic push_op(input int f, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({ADDR_W'(k), ref_elem(f, int'(mem[k]))});
  endtask

  // Monitor: every write the DUT presents is popped and compared.
  always @(negedge clk) begin
    logic [ADDR_W+WIDTH-1:0] e;
    if (done) done_cnt++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[ADDR_W+WIDTH-1:WIDTH]));
        chk("wr_data", 32'(wr_data), 32'(e[WIDTH-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse start for one cycle; returns at mid cycle 1 of the op.
  task automatic go(input logic [WIDTH-1:0] f, input logic with_abort);
    @(negedge clk);
    start  = 1'b1;
    factor = f;
    abort  = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Bounded wait for the done pulse; returns in the done cycle.
  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_rd_en"},   32'(rd_en),   32'd0);
    chk({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({name, "_wr_en"},   32'(wr_en),   32'd0);
    chk({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({name, "_busy"},    32'(busy),    32'd0);
    chk({name, "_done"},    32'(done),    32'd0);
    chk({name, "_ovf"},     32'(ovf),     32'd0);
  endtask

  task automatic full_op(input string name, input logic [WIDTH-1:0] f);
    push_op(int'(f), N);
    exp_done++;
    go(f, 1'b0);
    wait_done({name, "_done"});
    chk({name, "_ovf"}, 32'(ovf), 32'(ref_ovf(int'(f))));
    chk({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] f;
    n_cmp = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
    start = 1'b0; abort = 1'b0; factor = '0; rst_n = 1'b0;
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: factor 3, matrix[k]=k, exact cycle timing.
    for (int k = 0; k < N; k++) mem[k] = WIDTH'(k);
    push_op(3, N);
    exp_done++;
    go(8'd3, 1'b0);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_rd_en", 32'(rd_en), 32'd1);
    chk("t1_c1_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    chk("t1_c2_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk("t1_c3_wr_en", 32'(wr_en), 32'd1);
    repeat (24) @(negedge clk);
    chk("t1_c27_wr_en", 32'(wr_en), 32'd1);
    chk("t1_c27_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("t1_c28_done", 32'(done), 32'd1);
    chk("t1_c28_busy", 32'(busy), 32'd0);
    abort = 1'b1;  // abort in DONE has no effect
    @(negedge clk);
    abort = 1'b0;
    chk("t1_c29_done", 32'(done), 32'd0);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: factor 16 on element 0x20 (wraps to 0, or clamps and sets ovf).
    for (int k = 0; k < N; k++) mem[k] = WIDTH'($urandom_range(0, 15));
    mem[0] = 8'h20;
    full_op("t2", 8'd16);

    // 3: abort in cycle 10; ovf cleared by the accepted start.
    for (int k = 0; k < N; k++) mem[k] = WIDTH'($urandom);
    f = WIDTH'($urandom);
    push_op(int'(f), 8);
    go(f, 1'b0);
    chk("t3_c1_ovf", 32'(ovf), 32'd0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_c11_busy", 32'(busy), 32'd0);
    chk("t3_c11_rd_en", 32'(rd_en), 32'd0);
    chk("t3_c11_wr_en", 32'(wr_en), 32'd0);
    repeat (30) @(negedge clk);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    // New op with start and abort together in IDLE: start wins.
    f = WIDTH'($urandom);
    push_op(int'(f), N);
    exp_done++;
    go(f, 1'b1);
    chk("t3b_c1_busy", 32'(busy), 32'd1);
    wait_done("t3b_done");
    chk("t3b_q_empty", 32'(exp_q.size()), 32'd0);

    // 4: start pulses in cycles 5 and 28 are ignored.
    f = WIDTH'($urandom);
    push_op(int'(f), N);
    exp_done++;
    go(f, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    factor = ~f;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_c29_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_c30_busy", 32'(busy), 32'd0);
    chk("t4_c30_rd_en", 32'(rd_en), 32'd0);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset in cycle 12 discards the op.
    for (int k = 0; k < N; k++) mem[k] = WIDTH'($urandom_range(128, 255));
    push_op(255, 10);
    go(8'hFF, 1'b0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5_reset");
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: factor 0xFF on all ones, then factor 0.
    for (int k = 0; k < N; k++) mem[k] = 8'h01;
    full_op("t6a", 8'hFF);
    full_op("t6b", 8'h00);

    // Random ops.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < N; k++) mem[k] = WIDTH'($urandom);
      full_op("rand", WIDTH'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
